// File: rtl/cash_dispenser_if.sv
// Handshake bundle between the withdrawal controller (master) and the note dispenser (slave).
interface cash_dispenser_if;
  logic       req;
  logic [7:0] amount;
  logic       refill;
  logic       note_ack;
  logic       busy;
  logic       note_valid;
  logic [5:0] note_sel;
  logic       done;
  logic       err;
  logic [5:0] stock_empty;

  modport master (output req, amount, refill, note_ack,
                  input  busy, note_valid, note_sel, done, err, stock_empty);
  modport slave  (input  req, amount, refill, note_ack,
                  output busy, note_valid, note_sel, done, err, stock_empty);
endinterface

// File: rtl/cash_dispenser.sv
// Greedy note payout (largest denomination first) with a dry run on shadow stock so a
// payout either completes fully or is rejected before any note moves.
module cash_dispenser #(
  parameter int INIT_NOTES = 10,
  parameter int CNT_W      = 4
) (
  input logic             clk,
  input logic             res,
  cash_dispenser_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    DISPENSE = 3'd2,
    PRESENT  = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(INIT_NOTES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);
  localparam logic [2:0]       TOP  = 3'd5;

  state_t           state_r, state_next;
  logic [7:0]       amount_r, amount_next;
  logic [7:0]       rem_r, rem_next;
  logic [2:0]       ptr_r, ptr_next;
  logic [CNT_W-1:0] stock_r     [6];
  logic [CNT_W-1:0] stock_next  [6];
  logic [CNT_W-1:0] shadow_r    [6];
  logic [CNT_W-1:0] shadow_next [6];
  logic [7:0]       val_s;
  logic             shadow_ok_s;
  logic             stock_ok_s;
  logic [5:0]       stock_empty_s;

  function automatic logic [7:0] denom_val(input logic [2:0] p);
    case (p)
      3'd0:    denom_val = 8'd1;
      3'd1:    denom_val = 8'd5;
      3'd2:    denom_val = 8'd10;
      3'd3:    denom_val = 8'd20;
      3'd4:    denom_val = 8'd50;
      3'd5:    denom_val = 8'd100;
      default: denom_val = 8'd255;
    endcase
  endfunction

  // Greedy guards: can the current denomination be taken from shadow / real stock
  always_comb begin
    val_s       = denom_val(ptr_r);
    shadow_ok_s = (rem_r >= val_s) && (shadow_r[ptr_r] != ZERO);
    stock_ok_s  = (rem_r >= val_s) && (stock_r[ptr_r] != ZERO);
  end

  // Next-state and datapath updates
  always_comb begin
    state_next  = state_r;
    amount_next = amount_r;
    rem_next    = rem_r;
    ptr_next    = ptr_r;
    stock_next  = stock_r;
    shadow_next = shadow_r;
    case (state_r)
      IDLE: begin
        if (bus.req) begin
          amount_next = bus.amount;
          rem_next    = bus.amount;
          shadow_next = stock_r;
          ptr_next    = TOP;
          state_next  = CHECK;
        end else if (bus.refill) begin
          for (int i = 0; i < 6; i++) stock_next[i] = FULL;
        end else begin
          state_next = IDLE;
        end
      end
      CHECK: begin
        if (shadow_ok_s) begin
          rem_next           = rem_r - val_s;
          shadow_next[ptr_r] = shadow_r[ptr_r] - ONE;
        end else if (ptr_r != 3'd0) begin
          ptr_next = ptr_r - 3'd1;
        end else if (rem_r == 8'd0) begin
          rem_next   = amount_r;
          ptr_next   = TOP;
          state_next = DISPENSE;
        end else begin
          state_next = ERR;
        end
      end
      DISPENSE: begin
        if (rem_r == 8'd0) begin
          state_next = DONE;
        end else if (stock_ok_s) begin
          state_next = PRESENT;
        end else if (ptr_r != 3'd0) begin
          ptr_next = ptr_r - 3'd1;
        end else begin
          // Unreachable once the dry run has passed; bail out rather than hang
          state_next = ERR;
        end
      end
      PRESENT: begin
        if (bus.note_ack) begin
          stock_next[ptr_r] = stock_r[ptr_r] - ONE;
          rem_next          = rem_r - val_s;
          state_next        = DISPENSE;
        end else begin
          state_next = PRESENT;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and output registers; outputs are loaded from the upcoming state
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r        <= IDLE;
      amount_r       <= 8'd0;
      rem_r          <= 8'd0;
      ptr_r          <= TOP;
      for (int i = 0; i < 6; i++) begin
        stock_r[i]  <= FULL;
        shadow_r[i] <= FULL;
      end
      bus.busy       <= 1'b0;
      bus.note_valid <= 1'b0;
      bus.note_sel   <= 6'b000000;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      state_r        <= state_next;
      amount_r       <= amount_next;
      rem_r          <= rem_next;
      ptr_r          <= ptr_next;
      stock_r        <= stock_next;
      shadow_r       <= shadow_next;
      bus.busy       <= (state_next != IDLE);
      bus.note_valid <= (state_next == PRESENT);
      bus.note_sel   <= (state_next == PRESENT) ? (6'b000001 << ptr_next) : 6'b000000;
      bus.done       <= (state_next == DONE);
      bus.err        <= (state_next == ERR);
    end
  end

  // Per-denomination empty flags
  always_comb begin
    for (int i = 0; i < 6; i++) stock_empty_s[i] = (stock_r[i] == ZERO);
  end

  assign bus.stock_empty = stock_empty_s;
endmodule
